// File: rtl/alarm_event_encoder.sv
// -----------------------------------------------------------------------------
// alarm_event_encoder
//
// Purpose:
//    Turns rising edges on four level alarm lines into a stream of 3-bit event
//    codes for the alarm distributor. Each zone latches one pending event.
//    Pending events are presented one at a time, with round-robin fairness,
//    through a valid/ready handshake. An edge that arrives while the zone
//    already holds a pending event is lost. Lost events are counted in a
//    saturating counter.
//
// Configuration:
//    ZONE_DEBOUNCE_EN (macro)
//       Undefined (default): edge = zone_in & ~zone_q.
//       Defined: adds a second sample stage zone_qq. A zone must be high for
//       two consecutive samples to count as an edge, so single-cycle glitches
//       are ignored and edge latency grows by one cycle.
//
// Ports:
//    clk         in   1            rising-edge clock
//    rst_n       in   1            asynchronous active-low reset
//    zone_in     in   4            level alarm lines, zones 0..3
//    code        out  3            {1, zone} while code_valid, else 000
//    code_valid  out  1            code holds an event
//    code_ready  in   1            downstream accepts code this cycle
//    pending     out  4            latched events not yet presented
//    drop_cnt    out  DROP_CNT_W   saturating count of lost events
// -----------------------------------------------------------------------------
module alarm_event_encoder #(
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            zone_in,
   output logic [2:0]            code,
   output logic                  code_valid,
   input  logic                  code_ready,
   output logic [3:0]            pending,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   localparam int SUM_W = DROP_CNT_W + 3;
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

   // Number of set bits in a 4-bit mask (0..4)
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [3:0]              zone_q_r;
   logic [3:0]              edge_s;
   logic [3:0]              pending_r;
   logic [3:0]              pending_nxt_s;
   logic [3:0]              clear_s;
   logic [3:0]              drop_mask_s;
   logic [DROP_CNT_W-1:0]   drop_r;
   logic [DROP_CNT_W-1:0]   drop_nxt_s;
   logic [SUM_W-1:0]        drop_sum_s;
   logic [1:0]              last_grant_r;
   logic [1:0]              last_grant_nxt_s;
   logic                    sel_found_s;
   logic [1:0]              sel_zone_s;
   logic [1:0]              cand_s;
   logic [2:0]              code_r;
   logic [2:0]              code_nxt_s;
   logic                    valid_r;
   logic                    valid_nxt_s;

`ifdef ZONE_DEBOUNCE_EN
   logic [3:0]              zone_qq_r;

   // Two-stage input sampling for debounced edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zone_q_r  <= 4'b0000;
         zone_qq_r <= 4'b0000;
      end else begin
         zone_q_r  <= zone_in;
         zone_qq_r <= zone_q_r;
      end
   end

   // A zone must be high on two consecutive samples, after being low before them
   always_comb begin
      edge_s = zone_in & zone_q_r & ~zone_qq_r;
   end
`else
   // Single-stage input sampling for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zone_q_r <= 4'b0000;
      end else begin
         zone_q_r <= zone_in;
      end
   end

   // Rising edge: high now, low on the previous sample
   always_comb begin
      edge_s = zone_in & ~zone_q_r;
   end
`endif

   // Round-robin pick: first pending zone at or after last_grant+1 (mod 4)
   always_comb begin
      sel_found_s = 1'b0;
      sel_zone_s  = 2'b00;
      cand_s      = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         cand_s = last_grant_r + 2'(k);
         if (!sel_found_s && pending_r[cand_s]) begin
            sel_found_s = 1'b1;
            sel_zone_s  = cand_s;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pending_r != 4'b0000) begin
               state_nxt_s = ST_PRESENT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PRESENT: begin
            if (code_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PRESENT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs: next code/valid, pending clear strobe and grant pointer update
   always_comb begin
      code_nxt_s       = code_r;
      valid_nxt_s      = valid_r;
      clear_s          = 4'b0000;
      last_grant_nxt_s = last_grant_r;
      case (state_r)
         ST_IDLE: begin
            // code_ready is ignored here because nothing is presented
            if (sel_found_s) begin
               code_nxt_s          = {1'b1, sel_zone_s};
               valid_nxt_s         = 1'b1;
               clear_s[sel_zone_s] = 1'b1;
            end else begin
               code_nxt_s  = 3'b000;
               valid_nxt_s = 1'b0;
            end
         end
         ST_PRESENT: begin
            if (code_ready) begin
               code_nxt_s       = 3'b000;
               valid_nxt_s      = 1'b0;
               last_grant_nxt_s = code_r[1:0];
            end else begin
               code_nxt_s  = code_r;
               valid_nxt_s = valid_r;
            end
         end
         default: begin
            code_nxt_s  = 3'b000;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Pending set/clear and drop accounting.
   // A new edge always wins over the selection clear. An edge on the zone
   // being selected this cycle is therefore a fresh event, not a drop.
   always_comb begin
      drop_mask_s   = edge_s & pending_r & ~clear_s;
      pending_nxt_s = (pending_r & ~clear_s) | edge_s;
      drop_sum_s    = SUM_W'(drop_r) + SUM_W'(popcount4(drop_mask_s));
      if (drop_sum_s > SUM_W'(DROP_MAX)) begin
         drop_nxt_s = DROP_MAX;
      end else begin
         drop_nxt_s = drop_sum_s[DROP_CNT_W-1:0];
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r    <= 4'b0000;
         drop_r       <= '0;
         last_grant_r <= 2'd3;
         code_r       <= 3'b000;
         valid_r      <= 1'b0;
      end else begin
         pending_r    <= pending_nxt_s;
         drop_r       <= drop_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         code_r       <= code_nxt_s;
         valid_r      <= valid_nxt_s;
      end
   end

   assign code       = code_r;
   assign code_valid = valid_r;
   assign pending    = pending_r;
   assign drop_cnt   = drop_r;

endmodule

// File: tb/tb_alarm_event_encoder.sv
module tb_alarm_event_encoder;

   localparam int W    = 2;
   localparam int DMAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   zone_in;
   logic         code_ready;
   logic [2:0]   code;
   logic         code_valid;
   logic [3:0]   pending;
   logic [W-1:0] drop_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit m_pend [4];
   bit m_q    [4];
   bit m_qq   [4];
   int m_drop;
   bit m_busy;
   int m_zone;
   int m_last;

   alarm_event_encoder #(.DROP_CNT_W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .zone_in    (zone_in),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .pending    (pending),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   wire [9:0] dut_vec = {code, code_valid, pending, drop_cnt};

   function automatic logic [9:0] exp_vec();
      logic [2:0]   c;
      logic [3:0]   p;
      logic [W-1:0] d;
      c = m_busy ? 3'(4 + m_zone) : 3'b000;
      for (int i = 0; i < 4; i++) p[i] = m_pend[i];
      d = W'(m_drop);
      return {c, m_busy, p, d};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_pend[i] = 1'b0; m_q[i] = 1'b0; m_qq[i] = 1'b0;
      end
      m_drop = 0; m_busy = 1'b0; m_zone = 0; m_last = 3;
   endtask

   // Advance the model by one clock using the currently driven inputs, then clock the DUT
   task automatic tick();
      bit edg [4];
      bit clr [4];
      int drops;
      for (int i = 0; i < 4; i++) begin
`ifdef ZONE_DEBOUNCE_EN
         edg[i] = zone_in[i] && m_q[i] && !m_qq[i];
`else
         edg[i] = zone_in[i] && !m_q[i];
`endif
         clr[i] = 1'b0;
      end
      if (!m_busy) begin
         for (int k = 1; k <= 4; k++) begin
            int z;
            z = (m_last + k) % 4;
            if (!m_busy && m_pend[z]) begin
               m_busy = 1'b1; m_zone = z; clr[z] = 1'b1;
            end
         end
      end else if (code_ready) begin
         m_busy = 1'b0; m_last = m_zone;
      end
      drops = 0;
      for (int i = 0; i < 4; i++) begin
         if (edg[i] && m_pend[i] && !clr[i]) drops++;
         m_pend[i] = (m_pend[i] && !clr[i]) || edg[i];
         m_qq[i]   = m_q[i];
         m_q[i]    = zone_in[i];
      end
      m_drop = (m_drop + drops > DMAX) ? DMAX : m_drop + drops;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input logic [3:0] z);
      rst_n      = 1'b0;
      zone_in    = z;
      code_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_dut(4'b0000);
      checks++;
      if (dut_vec !== 10'd0) begin
         failures++;
         $display("FAIL reset_state got=%b want=%b", dut_vec, 10'd0);
      end
   endtask

   task automatic test_single_event();
      int vcnt = 0;
      reset_dut(4'b0000);
      zone_in = 4'b0001; code_ready = 1'b1;
      tick();
      zone_in = 4'b0000;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL single_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec());
         end
         if (code_valid === 1'b1) begin
            vcnt++;
            checks++;
            if (code !== 3'b100) begin
               failures++;
               $display("FAIL single_code got=%b want=100", code);
            end
         end
      end
      checks++;
      if (vcnt != 1 || pending !== 4'b0000 || drop_cnt !== 2'b00) begin
         failures++;
         $display("FAIL single_summary valid_cycles=%0d pending=%b drop=%b want 1/0000/00",
                  vcnt, pending, drop_cnt);
      end
   endtask

   task automatic test_all_zones();
      int codes [$];
      int cyc   [$];
      reset_dut(4'b0000);
      zone_in = 4'b1111; code_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL allzones_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec());
         end
         if (code_valid === 1'b1) begin
            codes.push_back(int'(code));
            cyc.push_back(c);
         end
      end
      checks++;
      if (codes.size() != 4) begin
         failures++;
         $display("FAIL allzones_count got=%0d want=4", codes.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (codes[i] != 4 + i) begin
               failures++;
               $display("FAIL allzones_order idx=%0d got=%0d want=%0d", i, codes[i], 4 + i);
            end
            if (i > 0) begin
               checks++;
               if (cyc[i] - cyc[i-1] != 2) begin
                  failures++;
                  $display("FAIL allzones_gap idx=%0d got=%0d want=2", i, cyc[i] - cyc[i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_drop();
      logic [3:0] seq [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
      reset_dut(4'b0000);
      for (int c = 0; c < 6; c++) begin
         zone_in = seq[c];
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL drop_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec());
         end
      end
      checks++;
      if (code !== 3'b110 || code_valid !== 1'b1 || pending !== 4'b0010 || drop_cnt !== 2'd1) begin
         failures++;
         $display("FAIL drop_state got code=%b v=%b pend=%b drop=%0d want 110/1/0010/1",
                  code, code_valid, pending, drop_cnt);
      end
   endtask

   // Continues from test_drop: code_ready still 0, zone 2 presented
   task automatic test_saturation();
      for (int c = 0; c < 6; c++) begin
         zone_in = (c % 2 == 0) ? 4'b0000 : 4'b1111;
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL sat_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec());
         end
      end
      checks++;
      if (drop_cnt !== 2'b11 || code !== 3'b110) begin
         failures++;
         $display("FAIL sat_hold got drop=%b code=%b want 11/110", drop_cnt, code);
      end
   endtask

   // Continues from test_saturation: transfer in progress, drops and pending nonzero
   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec !== 10'd0) begin
         failures++;
         $display("FAIL async_reset got=%b want=%b", dut_vec, 10'd0);
      end
      model_reset();
      zone_in = 4'b0000;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_held_high();
      reset_dut(4'b1000);
      tick();
      checks++;
      if (pending !== 4'b1000 || dut_vec !== exp_vec()) begin
         failures++;
         $display("FAIL held_high got=%b want=%b", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      reset_dut(4'b0000);
      for (int c = 0; c < 400; c++) begin
         zone_in    = 4'($urandom_range(0, 15));
         code_ready = ($urandom_range(0, 3) != 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; zone_in = 4'b0000; code_ready = 1'b0;
      test_reset();
      test_single_event();
      test_all_zones();
      test_drop();
      test_saturation();
      test_async_reset();
      test_held_high();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
